// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: EX/MEM register, byte-addressable data RAM with
// optional wait states, load alignment/extension and branch resolution.
module mem_stage_pipe #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TAG_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic              ex_wmem,
    input  logic [1:0]        ex_size,
    input  logic              ex_sext,
    input  logic              ex_branch,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_pc,
    input  logic [DATA_W-1:0] ex_aluR,
    input  logic [DATA_W-1:0] ex_inB,
    input  logic [4:0]        ex_destR,
    input  logic [TAG_W-1:0]  ex_tag,
    output logic              mem_valid,
    output logic              mem_wreg,
    output logic              mem_m2reg,
    output logic [DATA_W-1:0] mem_aluR,
    output logic [DATA_W-1:0] mem_pc,
    output logic [DATA_W-1:0] mem_mdata,
    output logic [4:0]        mem_destR,
    output logic [TAG_W-1:0]  mem_tag,
    output logic              mem_branch,
    output logic              mem_stall,
    output logic              mem_misalign
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               r_valid, r_wreg, r_m2reg, r_wmem, r_sext, r_branch, r_zero;
    logic [1:0]         r_size;
    logic [DATA_W-1:0]  r_pc, r_alu, r_inb;
    logic [4:0]         r_dest;
    logic [TAG_W-1:0]   r_tag;

    logic [DATA_W-1:0]  ram [DEPTH];
    logic [IDX_W-1:0]   widx;
    logic [DATA_W-1:0]  rword;
    logic [7:0]         rbyte;
    logic [15:0]        rhalf;
    logic [3:0]         wmask;
    logic [DATA_W-1:0]  wdata;
    logic               misaligned;
    logic               mem_op;
    logic               capture_mem;
    logic               ram_we;

    // Stall only while a multi-cycle access still has wait cycles left
    assign mem_stall   = (state_q == BUSY) && (cnt_q != CNT_W'(0));
    assign capture_mem = ~flush & ~mem_stall & ex_valid & (ex_m2reg | ex_wmem);

    // EX/MEM pipeline register: flush beats stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_wmem   <= 1'b0;
            r_size   <= 2'b00;
            r_sext   <= 1'b0;
            r_branch <= 1'b0;
            r_zero   <= 1'b0;
            r_pc     <= '0;
            r_alu    <= '0;
            r_inb    <= '0;
            r_dest   <= '0;
            r_tag    <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
        end else if (!mem_stall) begin
            r_valid  <= ex_valid;
            r_wreg   <= ex_wreg;
            r_m2reg  <= ex_m2reg;
            r_wmem   <= ex_wmem;
            r_size   <= ex_size;
            r_sext   <= ex_sext;
            r_branch <= ex_branch;
            r_zero   <= ex_zero;
            r_pc     <= ex_pc;
            r_alu    <= ex_aluR;
            r_inb    <= ex_inB;
            r_dest   <= ex_destR;
            r_tag    <= ex_tag;
        end
    end

    // Wait-state FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Wait-state FSM next state: a new access may chain at the completing edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (capture_mem && (WAIT_STATES != 0)) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_W'(0)) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end else if (capture_mem) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Alignment check and memory-op qualification
    always_comb begin
        misaligned = 1'b0;
        case (r_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = r_alu[0];
            default: misaligned = (r_alu[1:0] != 2'b00);
        endcase
    end

    assign mem_op = r_valid & (r_m2reg | r_wmem);
    assign widx   = r_alu[ADDR_W-1:2];
    assign ram_we = r_valid & r_wmem & ~misaligned & ~mem_stall & ~flush;

    // Store lane mask and replicated store data
    always_comb begin
        wmask = 4'b0000;
        wdata = '0;
        case (r_size)
            2'b00: begin
                wmask = 4'b0001 << r_alu[1:0];
                wdata = {4{r_inb[7:0]}};
            end
            2'b01: begin
                wmask = r_alu[1] ? 4'b1100 : 4'b0011;
                wdata = {2{r_inb[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = r_inb;
            end
        endcase
    end

    // Data RAM byte-lane write; contents are not reset
    always_ff @(posedge clk) begin
        if (ram_we && wmask[0]) ram[widx][7:0]   <= wdata[7:0];
        if (ram_we && wmask[1]) ram[widx][15:8]  <= wdata[15:8];
        if (ram_we && wmask[2]) ram[widx][23:16] <= wdata[23:16];
        if (ram_we && wmask[3]) ram[widx][31:24] <= wdata[31:24];
    end

    // Asynchronous read with lane select and extension
    always_comb begin
        rword     = ram[widx];
        rhalf     = r_alu[1] ? rword[31:16] : rword[15:0];
        rbyte     = rword[7:0];
        mem_mdata = '0;
        case (r_alu[1:0])
            2'b00:   rbyte = rword[7:0];
            2'b01:   rbyte = rword[15:8];
            2'b10:   rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        if (r_valid && r_m2reg) begin
            case (r_size)
                2'b00:   mem_mdata = {{(DATA_W-8){r_sext & rbyte[7]}}, rbyte};
                2'b01:   mem_mdata = {{(DATA_W-16){r_sext & rhalf[15]}}, rhalf};
                default: mem_mdata = rword;
            endcase
        end
    end

    // Gated control and forwarded fields toward WB
    assign mem_valid    = r_valid;
    assign mem_wreg     = r_valid & r_wreg & ~(r_m2reg & misaligned);
    assign mem_m2reg    = r_valid & r_m2reg;
    assign mem_branch   = r_valid & r_branch & r_zero;
    assign mem_misalign = mem_op & misaligned;
    assign mem_aluR     = r_alu;
    assign mem_pc       = r_pc;
    assign mem_destR    = r_dest;
    assign mem_tag      = r_tag;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: one zero-wait instance and one three-wait instance
// checked against a byte-array memory model.
module tb_mem_stage_pipe;

    localparam int unsigned AW   = 10;
    localparam int unsigned WS_S = 3;

    typedef struct packed {
        logic        valid, wreg, m2reg, wmem;
        logic [1:0]  size;
        logic        sext, branch, zero;
        logic [31:0] pc, alu, inb;
        logic [4:0]  dest;
        logic [7:0]  tag;
    } op_t;

    typedef struct packed {
        logic        valid, wreg, m2reg, branch, stall, misalign;
        logic [31:0] alu, pc, mdata;
        logic [4:0]  dest;
        logic [7:0]  tag;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush_f, flush_s;
    op_t  in_f, in_s;

    logic        f_valid, f_wreg, f_m2reg, f_branch, f_stall, f_mis;
    logic [31:0] f_alu, f_pc, f_mdata;
    logic [4:0]  f_dest;
    logic [7:0]  f_tag;
    logic        s_valid, s_wreg, s_m2reg, s_branch, s_stall, s_mis;
    logic [31:0] s_alu, s_pc, s_mdata;
    logic [4:0]  s_dest;
    logic [7:0]  s_tag;

    logic [7:0] mm [2][1 << AW];
    int n_checks = 0;
    int n_errors = 0;
    int we_cnt_s = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.DATA_W(32), .ADDR_W(AW), .WAIT_STATES(0), .TAG_W(8)) u_f (
        .clk(clk), .rst_n(rst_n), .flush(flush_f),
        .ex_valid(in_f.valid), .ex_wreg(in_f.wreg), .ex_m2reg(in_f.m2reg), .ex_wmem(in_f.wmem),
        .ex_size(in_f.size), .ex_sext(in_f.sext), .ex_branch(in_f.branch), .ex_zero(in_f.zero),
        .ex_pc(in_f.pc), .ex_aluR(in_f.alu), .ex_inB(in_f.inb), .ex_destR(in_f.dest), .ex_tag(in_f.tag),
        .mem_valid(f_valid), .mem_wreg(f_wreg), .mem_m2reg(f_m2reg), .mem_aluR(f_alu), .mem_pc(f_pc),
        .mem_mdata(f_mdata), .mem_destR(f_dest), .mem_tag(f_tag), .mem_branch(f_branch),
        .mem_stall(f_stall), .mem_misalign(f_mis));

    mem_stage_pipe #(.DATA_W(32), .ADDR_W(AW), .WAIT_STATES(WS_S), .TAG_W(8)) u_s (
        .clk(clk), .rst_n(rst_n), .flush(flush_s),
        .ex_valid(in_s.valid), .ex_wreg(in_s.wreg), .ex_m2reg(in_s.m2reg), .ex_wmem(in_s.wmem),
        .ex_size(in_s.size), .ex_sext(in_s.sext), .ex_branch(in_s.branch), .ex_zero(in_s.zero),
        .ex_pc(in_s.pc), .ex_aluR(in_s.alu), .ex_inB(in_s.inb), .ex_destR(in_s.dest), .ex_tag(in_s.tag),
        .mem_valid(s_valid), .mem_wreg(s_wreg), .mem_m2reg(s_m2reg), .mem_aluR(s_alu), .mem_pc(s_pc),
        .mem_mdata(s_mdata), .mem_destR(s_dest), .mem_tag(s_tag), .mem_branch(s_branch),
        .mem_stall(s_stall), .mem_misalign(s_mis));

    // Count RAM write edges of the wait-state instance
    always @(posedge clk) begin
        if (u_s.ram_we) we_cnt_s <= we_cnt_s + 1;
    end

    task automatic get_out(input int s, output out_t o);
        if (s == 1) begin
            o.valid = s_valid; o.wreg = s_wreg; o.m2reg = s_m2reg; o.branch = s_branch;
            o.stall = s_stall; o.misalign = s_mis; o.alu = s_alu; o.pc = s_pc;
            o.mdata = s_mdata; o.dest = s_dest; o.tag = s_tag;
        end else begin
            o.valid = f_valid; o.wreg = f_wreg; o.m2reg = f_m2reg; o.branch = f_branch;
            o.stall = f_stall; o.misalign = f_mis; o.alu = f_alu; o.pc = f_pc;
            o.mdata = f_mdata; o.dest = f_dest; o.tag = f_tag;
        end
    endtask

    task automatic drive(input int s, input op_t op);
        if (s == 1) in_s = op;
        else        in_f = op;
    endtask

    function automatic bit is_mis(input op_t op);
        if (op.size == 2'b01) return op.alu[0];
        if (op.size[1])       return op.alu[1:0] != 2'b00;
        return 1'b0;
    endfunction

    // Little-endian read from the byte model, extended as the load asks
    function automatic logic [31:0] model_load(input int s, input logic [31:0] a,
                                               input logic [1:0] size, input logic sext);
        int base;
        int h;
        logic [7:0]  b;
        logic [15:0] hw;
        base = int'(a[AW-1:2]) * 4;
        if (size == 2'b00) begin
            b = mm[s][base + int'(a[1:0])];
            if (sext && b[7]) return 32'hFFFF_FF00 | {24'h0, b};
            return {24'h0, b};
        end
        if (size == 2'b01) begin
            h  = base + (a[1] ? 2 : 0);
            hw = {mm[s][h+1], mm[s][h]};
            if (sext && hw[15]) return 32'hFFFF_0000 | {16'h0, hw};
            return {16'h0, hw};
        end
        return {mm[s][base+3], mm[s][base+2], mm[s][base+1], mm[s][base]};
    endfunction

    task automatic model_store(input int s, input op_t op);
        int base;
        int n;
        int first;
        logic [31:0] d;
        if (!(op.valid && op.wmem) || is_mis(op)) return;
        base  = int'(op.alu[AW-1:2]) * 4;
        n     = (op.size == 2'b00) ? 1 : (op.size == 2'b01) ? 2 : 4;
        first = base + ((n == 4) ? 0 : int'(op.alu[1:0]));
        d     = op.inb;
        for (int i = 0; i < n; i++) begin
            mm[s][first + i] = d[7:0];
            d = d >> 8;
        end
    endtask

    function automatic out_t expect_out(input int s, input op_t op);
        out_t e;
        bit   mis;
        mis        = is_mis(op);
        e.valid    = op.valid;
        e.wreg     = op.valid & op.wreg & ~(op.m2reg & mis);
        e.m2reg    = op.valid & op.m2reg;
        e.branch   = op.valid & op.branch & op.zero;
        e.stall    = 1'b0;
        e.misalign = op.valid & (op.m2reg | op.wmem) & mis;
        e.alu      = op.alu;
        e.pc       = op.pc;
        e.mdata    = (op.valid && op.m2reg) ? model_load(s, op.alu, op.size, op.sext) : 32'h0;
        e.dest     = op.dest;
        e.tag      = op.tag;
        return e;
    endfunction

    function automatic op_t rand_op();
        op_t op;
        int  kind;
        op       = '0;
        kind     = int'($urandom_range(0, 3));
        op.valid = ($urandom_range(0, 7) != 0);
        op.size  = 2'($urandom_range(0, 3));
        op.sext  = 1'($urandom_range(0, 1));
        op.zero  = 1'($urandom_range(0, 1));
        op.pc    = $urandom;
        op.alu   = $urandom;
        op.inb   = $urandom;
        op.dest  = 5'($urandom_range(0, 31));
        op.tag   = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) op.alu[1:0] = 2'b00;
        case (kind)
            0: op.wreg = 1'b1;
            1: begin op.wreg = 1'b1; op.m2reg = 1'b1; end
            2: op.wmem = 1'b1;
            default: op.branch = 1'b1;
        endcase
        return op;
    endfunction

    function automatic op_t mk_mem(input bit ld, input bit st, input logic [1:0] size,
                                   input bit sext, input logic [31:0] a, input logic [31:0] d);
        op_t op;
        op       = rand_op();
        op.valid = 1'b1;
        op.wreg  = ld;
        op.m2reg = ld;
        op.wmem  = st;
        op.size  = size;
        op.sext  = sext;
        op.branch = 1'b0;
        op.alu   = a;
        op.inb   = d;
        return op;
    endfunction

    // Issue one instruction, scramble inputs while stalled, check on completion
    task automatic run_op(input int s, input op_t op, output out_t o);
        out_t e;
        int   sc;
        int   exp_sc;
        e      = expect_out(s, op);
        exp_sc = (s == 1 && op.valid && (op.m2reg || op.wmem)) ? int'(WS_S) : 0;
        drive(s, op);
        @(posedge clk);
        #1;
        model_store(s, op);
        if (s == 1) drive(s, rand_op());
        else        drive(s, '0);
        @(negedge clk);
        sc = 0;
        while (((s == 1) ? s_stall : f_stall) && sc < 40) begin
            sc++;
            @(negedge clk);
        end
        drive(s, '0);
        n_checks++;
        if (sc != exp_sc) begin
            n_errors++;
            $display("FAIL stall_cycles dut%0d: got %0d expected %0d", s, sc, exp_sc);
        end
        get_out(s, o);
        n_checks++;
        if (o !== e) begin
            n_errors++;
            $display("FAIL outputs dut%0d: got %h expected %h", s, o, e);
        end
    endtask

    task automatic idle(input int s);
        drive(s, '0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        out_t o;
        for (int s = 0; s < 2; s++) begin
            get_out(s, o);
            n_checks++;
            if (o !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs dut%0d: got %h expected 0", s, o);
            end
        end
    endtask

    task automatic test_init_mem();
        out_t o;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < (1 << (AW - 2)); w++)
                run_op(s, mk_mem(0, 1, 2'b10, 0, 32'(w * 4), $urandom), o);
        idle(0);
        idle(1);
    endtask

    task automatic test_byte_half_word();
        out_t o;
        run_op(0, mk_mem(0, 1, 2'b10, 0, 32'h10, 32'h8899_AABB), o);
        run_op(0, mk_mem(1, 0, 2'b10, 0, 32'h10, 32'h0), o);
        n_checks++;
        if (o.mdata !== 32'h8899_AABB) begin
            n_errors++;
            $display("FAIL lw_after_sw: got %h expected 8899aabb", o.mdata);
        end
        run_op(0, mk_mem(0, 1, 2'b00, 0, 32'h13, 32'h1234_56CC), o);
        run_op(0, mk_mem(1, 0, 2'b00, 1, 32'h13, 32'h0), o);
        n_checks++;
        if (o.mdata !== 32'hFFFF_FFCC) begin
            n_errors++;
            $display("FAIL lb_sext: got %h expected ffffffcc", o.mdata);
        end
        run_op(0, mk_mem(1, 0, 2'b00, 0, 32'h13, 32'h0), o);
        n_checks++;
        if (o.mdata !== 32'h0000_00CC) begin
            n_errors++;
            $display("FAIL lbu: got %h expected 000000cc", o.mdata);
        end
        run_op(0, mk_mem(1, 0, 2'b01, 0, 32'h12, 32'h0), o);
        n_checks++;
        if (o.mdata !== 32'h0000_CC99) begin
            n_errors++;
            $display("FAIL lhu: got %h expected 0000cc99", o.mdata);
        end
        idle(0);
    endtask

    task automatic test_wait_states();
        out_t o;
        int   c0;
        c0 = we_cnt_s;
        run_op(1, mk_mem(0, 1, 2'b10, 0, 32'h40, 32'h1122_3344), o);
        run_op(1, mk_mem(1, 0, 2'b10, 0, 32'h40, 32'h0), o);
        n_checks++;
        if (o.mdata !== 32'h1122_3344) begin
            n_errors++;
            $display("FAIL ws_store_load: got %h expected 11223344", o.mdata);
        end
        n_checks++;
        if (we_cnt_s - c0 != 1) begin
            n_errors++;
            $display("FAIL ws_write_count: got %0d expected 1", we_cnt_s - c0);
        end
        idle(1);
    endtask

    task automatic test_flush_busy();
        out_t        o;
        logic [31:0] old;
        int          c0;
        old = model_load(1, 32'h20, 2'b10, 1'b0);
        c0  = we_cnt_s;
        drive(1, mk_mem(0, 1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF));
        @(posedge clk);
        #1;
        drive(1, '0);
        @(negedge clk);
        n_checks++;
        if (s_stall !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_pre_stall: got %b expected 1", s_stall);
        end
        flush_s = 1'b1;
        @(posedge clk);
        #1;
        flush_s = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({s_valid, s_stall} !== 2'b00) begin
            n_errors++;
            $display("FAIL flush_valid_stall: got %b expected 00", {s_valid, s_stall});
        end
        run_op(1, mk_mem(1, 0, 2'b10, 0, 32'h20, 32'h0), o);
        n_checks++;
        if (o.mdata !== old || we_cnt_s != c0) begin
            n_errors++;
            $display("FAIL flush_no_write: got %h/%0d expected %h/0", o.mdata, we_cnt_s - c0, old);
        end
        idle(1);
    endtask

    task automatic test_misalign();
        out_t        o;
        logic [31:0] old;
        for (int s = 0; s < 2; s++) begin
            run_op(s, mk_mem(1, 0, 2'b01, 1, 32'h11, 32'h0), o);
            n_checks++;
            if ({o.misalign, o.wreg} !== 2'b10) begin
                n_errors++;
                $display("FAIL lh_misalign dut%0d: got %b expected 10", s, {o.misalign, o.wreg});
            end
            old = model_load(s, 32'h20, 2'b10, 1'b0);
            run_op(s, mk_mem(0, 1, 2'b10, 0, 32'h22, 32'h5555_AAAA), o);
            run_op(s, mk_mem(1, 0, 2'b10, 0, 32'h20, 32'h0), o);
            n_checks++;
            if (o.mdata !== old) begin
                n_errors++;
                $display("FAIL sw_misalign_nowrite dut%0d: got %h expected %h", s, o.mdata, old);
            end
            idle(s);
        end
    endtask

    task automatic test_branch();
        out_t o;
        op_t  op;
        op = rand_op();
        op.valid = 1'b1; op.m2reg = 1'b0; op.wmem = 1'b0; op.branch = 1'b1; op.zero = 1'b1;
        run_op(0, op, o);
        n_checks++;
        if (o.branch !== 1'b1) begin
            n_errors++;
            $display("FAIL branch_taken: got %b expected 1", o.branch);
        end
        op.zero = 1'b0;
        run_op(0, op, o);
        n_checks++;
        if (o.branch !== 1'b0) begin
            n_errors++;
            $display("FAIL branch_not_zero: got %b expected 0", o.branch);
        end
        op.zero = 1'b1;
        drive(0, op);
        flush_f = 1'b1;
        @(posedge clk);
        #1;
        flush_f = 1'b0;
        drive(0, '0);
        @(negedge clk);
        n_checks++;
        if ({f_valid, f_branch} !== 2'b00) begin
            n_errors++;
            $display("FAIL branch_flushed: got %b expected 00", {f_valid, f_branch});
        end
    endtask

    task automatic test_back_to_back();
        out_t o;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 250; i++) run_op(s, rand_op(), o);
            idle(s);
        end
    endtask

    task automatic test_reset_busy();
        out_t        o;
        logic [31:0] old;
        old = model_load(1, 32'h30, 2'b10, 1'b0);
        drive(1, mk_mem(0, 1, 2'b10, 0, 32'h30, ~old));
        @(posedge clk);
        #1;
        drive(1, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        get_out(1, o);
        n_checks++;
        if (o !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_busy: got %h expected 0", o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1, mk_mem(1, 0, 2'b10, 0, 32'h30, 32'h0), o);
        n_checks++;
        if (o.mdata !== old) begin
            n_errors++;
            $display("FAIL reset_abort_store: got %h expected %h", o.mdata, old);
        end
        idle(1);
    endtask

    initial begin
        rst_n   = 1'b0;
        flush_f = 1'b0;
        flush_s = 1'b0;
        in_f    = '0;
        in_s    = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_init_mem();
        test_byte_half_word();
        test_wait_states();
        test_flush_busy();
        test_misalign();
        test_branch();
        test_back_to_back();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
